seq_subtractor: RTL and testbench
=================================

Name: seq_subtractor

Overview:
Multi-cycle N-bit subtractor computing diff = in1 - in2 - bin. It processes one 4-bit slice per clock, LSB slice first, and keeps a registered borrow between slices. It is the subtract-direction counterpart of the team's ripple-carry adder datapath. Datapath blocks that need wide subtraction at low area use it through a start/done handshake.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
SLICES, WIDTH/4, derived number of 4-bit slices; not overridable

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled on rising clk edge, honoured only while not busy
in1  input  WIDTH  minuend; captured at the accepted start edge
in2  input  WIDTH  subtrahend; captured at the accepted start edge
bin  input  1  borrow-in; captured at the accepted start edge
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse; result valid
diff  output  WIDTH  result; held until the next completion
bout  output  1  unsigned borrow-out; 1 iff in1 < in2 + bin
ovf  output  1  two's-complement signed overflow of the subtraction

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: on rst high, all of these go to 0 immediately, without waiting for a clock edge:
  - busy, done, diff, bout, ovf;
  - internal slice counter, borrow register and operand registers.
- Reset also forces the FSM to IDLE. An operation in flight is discarded, and no done pulse is produced for it.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 at edge k captures in1, in2 and bin into internal registers.
  - It clears the slice index to 0, loads the borrow register with bin, and moves to RUN.
  - busy=1 from edge k.
- RUN, edge k+1+i for i = 0..SLICES-1:
  - Compute slice i as a 4-bit subtract: in1[4i+3:4i] - in2[4i+3:4i] - borrow.
  - Store the slice result into an internal accumulator.
  - Update the borrow register with the slice borrow-out.
  - Increment the slice index.
- Completion, edge k+SLICES:
  - The last slice is computed.
  - diff, bout and ovf are loaded from the accumulator and the final borrow.
  - done=1 for exactly one cycle, busy=0, and the FSM returns to IDLE.
- Latency: start accepted at edge k means done is high in the cycle following edge k+SLICES; for WIDTH=16 that is 4 cycles.
- Throughput: one result per SLICES cycles.
- Outputs during RUN: diff, bout and ovf hold the previous result and never show partial values.
- Start while busy: ignored. Operands are not re-captured and no error is flagged.
- Start during the done cycle: accepted, because the FSM is already in IDLE. This gives back-to-back operations with busy re-asserting at that edge.
- Input stability: in1, in2 and bin need only be stable at the accepted start edge. Later changes have no effect on the result.
- Arithmetic rules:
  - diff = (in1 - in2 - bin) mod 2^WIDTH.
  - bout = final slice borrow.
  - ovf = (in1[MSB] != in2[MSB]) && (diff[MSB] != in1[MSB]).
- Wrap-around: 0 - 0 - 1 gives diff all-ones and bout=1. The slice counter never exceeds SLICES-1.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> busy, done, diff, bout, ovf all 0 immediately, with no clock edge needed.
2. WIDTH=16, in1=0x1234, in2=0x0234, bin=0, start pulse -> busy high 4 cycles, then done pulses once; diff=0x1000, bout=0, ovf=0.
3. Full borrow chain: in1=0x0000, in2=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Repeat with in2=0x0000, bin=1 -> same result.
4. Signed overflow: in1=0x8000, in2=0x0001 -> diff=0x7FFF, bout=0, ovf=1. Borrow-in: in1=0x0005, in2=0x0003, bin=1 -> diff=0x0001, bout=0, ovf=0.
5. Handshake:
   - Start 0x0010-0x0001, then pulse start with new operands 2 cycles later while busy -> ignored; result 0x000F.
   - Assert start with 0x0003-0x0003 in the done cycle -> accepted; busy immediately; second done 4 cycles later with diff=0x0000.
6. Reset mid-operation: start 0xFFFF-0x0001, assert rst after 2 cycles -> no done; outputs 0. After release, 0x0100-0x0001 -> diff=0x00FF, bout=0.

Source files
------------

// File: rtl/seq_subtractor_if.sv
// Start/done handshake bundle for seq_subtractor: operands in, result and status out.
interface seq_subtractor_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;

    modport master (output start, in1, in2, bin, input busy, done, diff, bout, ovf);
    modport slave  (input start, in1, in2, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor: diff = in1 - in2 - bin, one 4-bit slice per clock, LSB slice first,
// with a registered borrow rippling between slices.
module seq_subtractor #(
    parameter int WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    seq_subtractor_if.slave  bus
);
    localparam int SLICES = WIDTH / 4;
    localparam int IW     = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state, state_next;
    logic [IW-1:0]          idx;
    logic                   brw;
    logic [SLICES-1:0][3:0] a, b, acc, acc_next;
    logic [4:0]             slice;
    logic                   accept, last;
    logic                   done_r, bout_r, ovf_r;
    logic [WIDTH-1:0]       diff_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = (idx == IW'(SLICES - 1));
        case (state)
            IDLE: if (bus.start) begin
                accept     = 1'b1;
                state_next = RUN;
            end
            RUN:  if (last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // 5-bit subtract: bit 4 is the slice borrow-out
        slice           = {1'b0, a[idx]} - {1'b0, b[idx]} - {4'b0, brw};
        acc_next        = acc;
        acc_next[idx]   = slice[3:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a      <= '0;
            b      <= '0;
            acc    <= '0;
            brw    <= 1'b0;
            idx    <= '0;
            done_r <= 1'b0;
            diff_r <= '0;
            bout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                a   <= bus.in1;
                b   <= bus.in2;
                brw <= bus.bin;
                idx <= '0;
            end else if (state == RUN) begin
                acc <= acc_next;
                brw <= slice[4];
                idx <= last ? '0 : idx + 1'b1;
                // Results are only published on the final slice, so outputs never show partials
                if (last) begin
                    done_r <= 1'b1;
                    diff_r <= acc_next;
                    bout_r <= slice[4];
                    ovf_r  <= (a[SLICES-1][3] != b[SLICES-1][3]) &&
                              (acc_next[SLICES-1][3] != a[SLICES-1][3]);
                end
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = done_r;
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_seq_subtractor.sv
// Bench for seq_subtractor: directed vector table, handshake/reset sequences, and random ops
// checked against an arithmetic reference model.
module tb_seq_subtractor;
    localparam int WIDTH = 16;
    localparam int LAT   = WIDTH / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    seq_subtractor_if #(.WIDTH(WIDTH)) bus ();
    seq_subtractor #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] in1;
        logic [15:0] in2;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, signed range test for overflow
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic b);
        logic [16:0] w;
        int          s;
        logic        o;
        w = {1'b0, x} - {1'b0, y} - {16'b0, b};
        s = int'($signed(x)) - int'($signed(y)) - int'(b);
        o = (s > 32767) || (s < -32768);
        return {o, w};
    endfunction

    task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic b);
        bus.in1   = x;
        bus.in2   = y;
        bus.bin   = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.in1   = ~x;
        bus.in2   = ~y;
        bus.bin   = ~b;
    endtask

    // lat = number of edges after the accept edge at which done was seen; -1 on timeout
    task automatic wait_done(input int already, output int lat);
        lat = -1;
        for (int i = already + 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = i;
                return;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] x, input logic [15:0] y,
                          input logic b, input logic [15:0] ed, input logic eb, input logic eo);
        int lat;
        start_op(x, y, b);
        chk({name, ".busy"}, 32'(bus.busy), 32'd1);
        wait_done(0, lat);
        chk({name, ".lat"}, 32'(lat), 32'(LAT));
        chk({name, ".diff"}, 32'(bus.diff), 32'(ed));
        chk({name, ".bout"}, 32'(bus.bout), 32'(eb));
        chk({name, ".ovf"}, 32'(bus.ovf), 32'(eo));
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [15:0] x, y;
        logic        b;
        logic [17:0] m;

        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        bus.start = 1'b0;
        bus.in1   = '0;
        bus.in2   = '0;
        bus.bin   = 1'b0;
        #1;
        chk("reset.busy", 32'(bus.busy), 32'd0);
        chk("reset.done", 32'(bus.done), 32'd0);
        chk("reset.diff", 32'(bus.diff), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].in1, vecs[i].in2, vecs[i].bin,
                   vecs[i].diff, vecs[i].bout, vecs[i].ovf);

        // Async reset with nonzero outputs present, mid-cycle, no edge in between
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("async_rst.diff", 32'(bus.diff), 32'd0);
        chk("async_rst.bout", 32'(bus.bout), 32'd0);
        chk("async_rst.ovf", 32'(bus.ovf), 32'd0);
        chk("async_rst.busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // Start while busy is ignored
        start_op(16'h0010, 16'h0001, 1'b0);
        @(posedge clk); #1;
        bus.in1 = 16'h5555; bus.in2 = 16'h1111; bus.bin = 1'b1; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_start.busy", 32'(bus.busy), 32'd1);
        wait_done(2, lat);
        chk("busy_start.lat", 32'(lat), 32'(LAT));
        chk("busy_start.diff", 32'(bus.diff), 32'h000F);

        // Start in the done cycle is accepted back-to-back
        start_op(16'h0003, 16'h0003, 1'b0);
        chk("b2b.busy", 32'(bus.busy), 32'd1);
        chk("b2b.done_low", 32'(bus.done), 32'd0);
        wait_done(0, lat);
        chk("b2b.lat", 32'(lat), 32'(LAT));
        chk("b2b.diff", 32'(bus.diff), 32'h0000);
        @(posedge clk); #1;
        chk("b2b.done_pulse", 32'(bus.done), 32'd0);

        // Reset mid-operation discards it
        run_op("pre_abort", 16'h0100, 16'h0002, 1'b0, 16'h00FE, 1'b0, 1'b0);
        start_op(16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("abort.busy", 32'(bus.busy), 32'd0);
        chk("abort.diff", 32'(bus.diff), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done) seen++;
        end
        chk("abort.no_done", 32'(seen), 32'd0);
        run_op("post_abort", 16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0);

        // Random operations against the reference model
        for (int i = 0; i < 25; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            b = 1'($urandom);
            if (i % 5 == 0) y = x;
            m = model(x, y, b);
            run_op($sformatf("rnd%0d", i), x, y, b, m[15:0], m[16], m[17]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
